// File: rtl/button_keyfifo.sv
// Debounces the 25-key scanner vector, turns debounced edges into 6-bit key codes and queues them
// in a first-word-fall-through FIFO. Optional release events: define BUTTON_RELEASE_EN.
module button_keyfifo #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20,
  parameter int FIFO_AW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [24:0]        btn,
  input  logic               rd_en,
  input  logic               clr_ovf,
  output logic [5:0]         key_code,
  output logic               key_valid,
  output logic [FIFO_AW:0]   count,
  output logic               overflow,
  output logic [24:0]        held
);

  localparam int              DEPTH  = 2 ** FIFO_AW;
  localparam int              PW     = FIFO_AW + 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  logic [24:0]     s1_q, s2_q, raw_last_q;
  logic [24:0]     stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic [24:0]     rise;
  logic [24:0]     pend_p_q, pend_p_d;
  logic            drain_valid;
  logic [5:0]      drain_code;
  logic [4:0]      drain_idx;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            full, push, pop;
  logic [5:0]      mem_q [DEPTH];
`ifdef BUTTON_RELEASE_EN
  logic [24:0]     fall;
  logic [24:0]     pend_r_q, pend_r_d;
`endif

  function automatic logic [4:0] lowest(input logic [24:0] v);
    lowest = '0;
    for (int i = 24; i >= 0; i--) begin
      if (v[i]) lowest = 5'(i);
    end
  endfunction

  // One counter for the whole vector: any bit change restarts the settle window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q != raw_last_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_MAX) begin
      stable_d = s2_q;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
    rise = stable_d & ~stable_q;
`ifdef BUTTON_RELEASE_EN
    fall = stable_q & ~stable_d;
`endif
  end

  // Presses drain first, lowest index first; a bit re-raised in the drain cycle stays pending.
  always_comb begin
    drain_valid = 1'b0;
    drain_idx   = lowest(pend_p_q);
    drain_code  = {1'b0, drain_idx};
    pend_p_d    = pend_p_q | rise;
`ifdef BUTTON_RELEASE_EN
    pend_r_d    = pend_r_q | fall;
`endif
    if (pend_p_q != '0) begin
      drain_valid = 1'b1;
      pend_p_d    = (pend_p_q & ~(25'(1) << drain_idx)) | rise;
    end
`ifdef BUTTON_RELEASE_EN
    else if (pend_r_q != '0) begin
      drain_valid = 1'b1;
      drain_idx   = lowest(pend_r_q);
      drain_code  = {1'b1, drain_idx};
      pend_r_d    = (pend_r_q & ~(25'(1) << drain_idx)) | fall;
    end
`endif
  end

  // Read side handshake: key_valid says key_code is the head; rd_en with key_valid pops it.
  // rd_en while key_valid=0 is ignored.
  always_comb begin
    full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    key_valid = (wr_ptr_q != rd_ptr_q);
    pop       = rd_en & key_valid;
    push      = drain_valid & (~full | pop);
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    ovf_d     = clr_ovf ? 1'b0 : (ovf_q | (drain_valid & full & ~pop));
    key_code  = key_valid ? mem_q[rd_ptr_q[FIFO_AW-1:0]] : '0;
    count     = wr_ptr_q - rd_ptr_q;
    overflow  = ovf_q;
    held      = stable_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      raw_last_q <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      pend_p_q   <= '0;
`ifdef BUTTON_RELEASE_EN
      pend_r_q   <= '0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_q       <= btn;
      s2_q       <= s1_q;
      raw_last_q <= s2_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      pend_p_q   <= pend_p_d;
`ifdef BUTTON_RELEASE_EN
      pend_r_q   <= pend_r_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= drain_code;
  end

endmodule

// File: tb/tb_button_keyfifo.sv
// Directed bench for button_keyfifo (DB_CYCLES=4, FIFO_AW=3); build with BUTTON_RELEASE_EN to
// cover release events.
module tb_button_keyfifo;
  localparam int DB_CYCLES = 4;
  localparam int DB_W      = 3;
  localparam int FIFO_AW   = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [24:0]        btn;
  logic               rd_en;
  logic               clr_ovf;
  logic [5:0]         key_code;
  logic               key_valid;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic [24:0]        held;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  button_keyfifo #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .key_code(key_code), .key_valid(key_valid), .count(count),
    .overflow(overflow), .held(held)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1ns after each rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  // scoreboard: compare and pop every expected head in order
  task automatic drain_expect(input string tag);
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, 32'(key_valid), 32'd1);
      check({tag, "_code"}, 32'(key_code), 32'(exp_q.pop_front()));
      pop1();
    end
    check({tag, "_empty"}, 32'(count), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; btn = 25'h1FFFFFF; rd_en = 1'b0; clr_ovf = 1'b0;
    step(3);
    check("rst_held", 32'(held), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    rst_n = 1'b1; btn = '0;
    step(6);

    // glitch shorter than the settle window
    btn[3] = 1'b1;
    step(3);
    btn[3] = 1'b0;
    step(10);
    check("glitch_held", 32'(held), 32'd0);
    check("glitch_valid", 32'(key_valid), 32'd0);

    // clean press of key 7
    btn[7] = 1'b1;
    step(6);
    check("press_held_early", 32'(held), 32'd0);
    step(1);
    check("press_held", 32'(held), 32'h80);
    check("press_valid_early", 32'(key_valid), 32'd0);
    step(1);
    check("press_valid", 32'(key_valid), 32'd1);
    check("press_code", 32'(key_code), 32'd7);
    check("press_count", 32'(count), 32'd1);
    pop1();
    check("pop_count", 32'(count), 32'd0);
    check("pop_valid", 32'(key_valid), 32'd0);
    check("pop_code", 32'(key_code), 32'd0);

    // simultaneous presses 24, 2, 0
    btn = btn | 25'h1000005;
    step(7);
    check("multi_held", 32'(held), 32'h1000085);
    step(1);
    check("multi_c1", 32'(count), 32'd1);
    check("multi_head", 32'(key_code), 32'd0);
    step(1);
    check("multi_c2", 32'(count), 32'd2);
    step(1);
    check("multi_c3", 32'(count), 32'd3);
    step(2);
    check("multi_c3_hold", 32'(count), 32'd3);
    exp_q = '{6'd0, 6'd2, 6'd24};
    drain_expect("multi");

    // nine presses (keys 8..16) into an 8-deep queue
    btn = btn | (25'h1FF << 8);
    step(15);
    check("full_count", 32'(count), 32'd8);
    check("full_no_ovf", 32'(overflow), 32'd0);
    step(1);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(key_code), 32'd8);
    step(2);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // key 17 arrives in the same cycle as a pop on the full queue
    btn[17] = 1'b1;
    step(7);
    check("pp_pre_count", 32'(count), 32'd8);
    pop1();
    check("pp_count", 32'(count), 32'd8);
    check("pp_head", 32'(key_code), 32'd9);
    check("pp_ovf", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_count", 32'(count), 32'd8);
    exp_q = '{6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd17};
    drain_expect("ovf_drain");

    // reset with an entry queued and keys held
    btn[20] = 1'b1;
    step(8);
    check("prerst_count", 32'(count), 32'd1);
    check("prerst_head", 32'(key_code), 32'd20);
    rst_n = 1'b0; btn = '0;
    step(2);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_held", 32'(held), 32'd0);
    check("midrst_valid", 32'(key_valid), 32'd0);
    rst_n = 1'b1;
    step(8);
    check("postrst_valid", 32'(key_valid), 32'd0);

    // press then release key 12
    btn[12] = 1'b1;
    step(7);
    check("k12_held", 32'(held), 32'h1000);
    step(1);
    check("k12_code", 32'(key_code), 32'd12);
    btn[12] = 1'b0;
    step(8);
    check("k12_rel_held", 32'(held), 32'd0);
`ifdef BUTTON_RELEASE_EN
    check("k12_rel_count", 32'(count), 32'd2);
    exp_q = '{6'd12, 6'h2C};
`else
    check("k12_rel_count", 32'(count), 32'd1);
    exp_q = '{6'd12};
`endif
    drain_expect("k12");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
